axis_rti_reader: RTL and testbench

//  Read side of the FMCW RTI line buffer (dual-port BRAM, 1-cycle read latency). On a start pulse,

---
 rtl/rti_pkg.sv | 27 ++
 rtl/rti_skid_fifo.sv | 67 ++++++
 rtl/axis_rti_reader.sv | 158 +++++++++++++++
 tb/tb_axis_rti_reader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rti_pkg.sv
// ============================================================================
// Module      : rti_pkg
// Description : Shared defaults and FSM encoding for the RTI line-buffer reader/writer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rti_pkg;

    localparam int c_RTI_ADDR_WIDTH = 12;
    localparam int c_RTI_DATA_WIDTH = 24;
    localparam int c_RTI_SIZE       = 4096;
    localparam int c_RTI_FIFO_DEPTH = 4;

    localparam int         c_ST_W     = 2;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    // Occupancy counters need one bit more than the pointer to represent "full".
    function automatic int rti_occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rti_skid_fifo.sv
// ============================================================================
// Module      : rti_skid_fifo
// Description : Small synchronous FIFO feeding the AXIS output; head is output directly.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rti_skid_fifo
    import rti_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 25
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            i_push,
    input  logic [WIDTH-1:0]                i_din,
    input  logic                            i_pop,
    output logic [WIDTH-1:0]                o_dout,
    output logic [rti_occ_width(DEPTH)-1:0] o_occ,
    output logic                            o_empty,
    output logic                            o_full
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_OCC_W = rti_occ_width(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_OCC_W-1:0] r_occ;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty   = (r_occ == '0);
    assign o_full    = (r_occ == c_OCC_W'(DEPTH));
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_occ     = r_occ;
    // Masking the head keeps the output at zero whenever nothing valid is held.
    assign o_dout    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_occ <= r_occ + c_OCC_W'(w_do_push) - c_OCC_W'(w_do_pop);
        end
    end

endmodule

`default_nettype wire

// File: rtl/axis_rti_reader.sv
// ============================================================================
// Module      : axis_rti_reader
// Description : Streams one RTI line from BRAM over AXI4-Stream, optional clear-on-read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_rti_reader
    import rti_pkg::*;
#(
    parameter int ADDR_WIDTH = c_RTI_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_RTI_DATA_WIDTH,
    parameter int SIZE       = c_RTI_SIZE,
    parameter int FIFO_DEPTH = c_RTI_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  clear_en,
    output logic                  busy,
    output logic                  overrun,
    output logic                  bram_ena,
    output logic [ADDR_WIDTH-1:0] bram_addra,
    input  logic [DATA_WIDTH-1:0] bram_doa,
    output logic                  bram_web,
    output logic [ADDR_WIDTH-1:0] bram_addrb,
    output logic [DATA_WIDTH-1:0] bram_dib,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    localparam int                    c_OCC_W     = rti_occ_width(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(SIZE - 1);

    logic [c_ST_W-1:0]     r_state;
    logic [c_ST_W-1:0]     w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_clr;
    logic                  r_busy;
    logic                  r_overrun;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic                  r_web;
    logic [ADDR_WIDTH-1:0] r_addrb;

    logic                  w_accept;
    logic                  w_issue;
    logic                  w_last_issue;
    logic                  w_pop;
    logic                  w_done;
    logic [DATA_WIDTH:0]   w_fifo_dout;
    logic [c_OCC_W-1:0]    w_occ;
    logic                  w_empty;
    logic                  w_full;

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (start)        w_state_nxt = c_ST_ISSUE;
            c_ST_ISSUE: if (w_last_issue) w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN: if (w_done)       w_state_nxt = c_ST_IDLE;
            default:                      w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Output / control decode. The in-flight read counts against FIFO space.
    always_comb begin
        w_accept     = 1'b0;
        w_issue      = 1'b0;
        w_last_issue = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_accept = start;
            end
            c_ST_ISSUE: begin
                w_issue      = ~w_full && ((int'(w_occ) + int'(r_inflight)) < FIFO_DEPTH);
                w_last_issue = w_issue && (r_rd_addr == c_LAST_ADDR);
            end
            c_ST_DRAIN: begin
                w_done = w_pop & w_fifo_dout[DATA_WIDTH];
            end
            default: begin
                w_accept = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rd_addr       <= '0;
            r_clr           <= 1'b0;
            r_busy          <= 1'b0;
            r_overrun       <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_web           <= 1'b0;
            r_addrb         <= '0;
        end else begin
            r_busy          <= (w_state_nxt != c_ST_IDLE);
            r_overrun       <= start & r_busy;
            r_inflight      <= w_issue;
            r_inflight_last <= w_last_issue;
            // Port B trails port A by a cycle so the clear lands after the read data is captured.
            r_web           <= w_issue & r_clr;
            r_addrb         <= bram_addra;
            if (w_accept) begin
                r_rd_addr <= '0;
                r_clr     <= clear_en;
            end else if (w_issue) begin
                r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
            end
        end
    end

    rti_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk    (clk),
        .rstn   (rstn),
        .i_push (r_inflight),
        .i_din  ({r_inflight_last, bram_doa}),
        .i_pop  (w_pop),
        .o_dout (w_fifo_dout),
        .o_occ  (w_occ),
        .o_empty(w_empty),
        .o_full (w_full)
    );

    assign w_pop         = m_axis_tvalid & m_axis_tready;
    assign m_axis_tvalid = ~w_empty;
    assign m_axis_tdata  = w_fifo_dout[DATA_WIDTH-1:0];
    assign m_axis_tlast  = w_fifo_dout[DATA_WIDTH];

    assign busy       = r_busy;
    assign overrun    = r_overrun;
    assign bram_ena   = w_issue;
    assign bram_addra = w_issue ? r_rd_addr : '0;
    assign bram_web   = r_web;
    assign bram_addrb = r_addrb;
    assign bram_dib   = '0;

endmodule

`default_nettype wire

// File: tb/tb_axis_rti_reader.sv
// ============================================================================
// Module      : tb_axis_rti_reader
// Description : Self-checking bench for axis_rti_reader with a BRAM model and line-level reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_rti_reader;

    localparam int AW = 12;
    localparam int DW = 24;
    localparam int SZ = 4096;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          clear_en = 1'b0;
    logic          busy;
    logic          overrun;
    logic          bram_ena;
    logic [AW-1:0] bram_addra;
    logic [DW-1:0] bram_doa = '0;
    logic          bram_web;
    logic [AW-1:0] bram_addrb;
    logic [DW-1:0] bram_dib;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;

    axis_rti_reader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SIZE(SZ), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .clear_en(clear_en),
        .busy(busy), .overrun(overrun),
        .bram_ena(bram_ena), .bram_addra(bram_addra), .bram_doa(bram_doa),
        .bram_web(bram_web), .bram_addrb(bram_addrb), .bram_dib(bram_dib),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
    );

    always #5 clk = ~clk;

    // BRAM model: read-first, 1-cycle read latency on port A, write on port B.
    logic [DW-1:0] mem [SZ];
    logic          preload_req = 1'b0;
    always @(posedge clk) begin
        if (preload_req) begin
            for (int i = 0; i < SZ; i++) mem[i] <= DW'(i * 3);
        end else if (bram_web) begin
            mem[bram_addrb] <= bram_dib;
        end
        if (bram_ena) bram_doa <= mem[bram_addra];
    end

    // Line-level reference: current BRAM contents and the line being streamed.
    int      total = 0;
    int      bad = 0;
    int      exp_line [SZ];
    int      exp_q [SZ];
    int      beat = 0, issued = 0, popped = 0, tlast_cnt = 0;
    int      cyc = 0, cyc_start = 0, cyc_end = 0;
    int      rdy_mode = 0;
    bit      m_busy = 0, line_clr = 0, prev_stall = 0, prev_tlast = 0;
    logic [DW-1:0] prev_tdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit            rst_now, hs, end_busy, exp_ovr, pena, clr_pre;
        logic [AW-1:0] paddr;
        if (rdy_mode == 1) m_axis_tready = 1'($urandom_range(0, 1));
        else               m_axis_tready = (rdy_mode == 0);
        rst_now  = !rstn;
        end_busy = 0;
        exp_ovr  = 0;
        hs       = 0;
        clr_pre  = line_clr;
        pena     = !rst_now && bram_ena;
        paddr    = bram_addra;
        if (!rst_now) begin
            hs = m_axis_tvalid && m_axis_tready;
            if (prev_stall) begin
                chk("hold_tvalid", m_axis_tvalid, 1);
                chk("hold_tdata", m_axis_tdata, prev_tdata);
                chk("hold_tlast", m_axis_tlast, prev_tlast);
            end
            if (bram_ena) begin
                chk("addra", bram_addra, issued);
                issued++;
            end
            chk("occ_bound", (issued - popped) <= FD, 1);
            if (hs) begin
                if (beat < SZ) begin
                    chk("tdata", m_axis_tdata, exp_q[beat]);
                    chk("tlast", m_axis_tlast, beat == SZ - 1);
                end else begin
                    chk("extra_beat", beat, SZ - 1);
                end
                if (m_axis_tlast) tlast_cnt++;
                beat++;
                popped++;
                if (beat == SZ) end_busy = 1;
            end
            if (start) begin
                if (m_busy) exp_ovr = 1;
                else begin
                    m_busy = 1; beat = 0; issued = 0; popped = 0;
                    line_clr = clear_en;
                    for (int i = 0; i < SZ; i++) begin
                        exp_q[i] = exp_line[i];
                        if (clear_en) exp_line[i] = 0;
                    end
                end
            end
            if (end_busy) m_busy = 0;
        end else begin
            m_busy = 0; beat = 0; issued = 0; popped = 0;
        end
        prev_stall = !rst_now && m_axis_tvalid && !m_axis_tready;
        prev_tdata = m_axis_tdata;
        prev_tlast = m_axis_tlast;
        @(posedge clk);
        #1;
        cyc++;
        if (end_busy) cyc_end = cyc;
        chk("busy", busy, m_busy);
        chk("overrun", overrun, exp_ovr);
        chk("web", bram_web, pena && clr_pre);
        if (pena && clr_pre) chk("addrb", bram_addrb, paddr);
        if (rst_now) begin
            chk("rst_tvalid", m_axis_tvalid, 0);
            chk("rst_tlast", m_axis_tlast, 0);
            chk("rst_tdata", m_axis_tdata, 0);
            chk("rst_ena", bram_ena, 0);
            chk("rst_addra", bram_addra, 0);
            chk("rst_addrb", bram_addrb, 0);
        end
    endtask

    task automatic preload();
        preload_req = 1'b1;
        step();
        preload_req = 1'b0;
        for (int i = 0; i < SZ; i++) exp_line[i] = i * 3;
    endtask

    task automatic start_line(input bit clr);
        start = 1'b1;
        clear_en = clr;
        step();
        start = 1'b0;
        clear_en = 1'b0;
        cyc_start = cyc;
    endtask

    task automatic run_idle();
        int n = 0;
        while (m_busy && n < 20000) begin step(); n++; end
        chk("line_timeout", m_busy, 0);
        step();
    endtask

    task automatic run_to_beat(input int target);
        int n = 0;
        while (m_busy && beat < target && n < 20000) begin step(); n++; end
        chk("reach_beat", beat >= target, 1);
    endtask

    initial begin
        rstn = 1'b0;
        preload();
        step();
        step();
        rstn = 1'b1;
        step();

        // 1: full line at full rate, latency and total duration
        rdy_mode = 0;
        tlast_cnt = 0;
        start_line(0);
        chk("t1_ena_first", bram_ena, 1);
        step();
        chk("t1_tvalid_e1", m_axis_tvalid, 0);
        step();
        chk("t1_tvalid_e2", m_axis_tvalid, 1);
        run_idle();
        chk("t1_duration", cyc_end - cyc_start, SZ + 2);
        chk("t1_tlast_cnt", tlast_cnt, 1);

        // 2: random backpressure
        rdy_mode = 1;
        tlast_cnt = 0;
        start_line(0);
        run_idle();
        chk("t2_beats", beat, SZ);
        chk("t2_tlast_cnt", tlast_cnt, 1);

        // 3: long stall right after start
        rdy_mode = 2;
        start_line(0);
        repeat (100) step();
        chk("t3_issued", issued, FD);
        chk("t3_ena_idle", bram_ena, 0);
        chk("t3_tvalid", m_axis_tvalid, 1);
        chk("t3_popped", popped, 0);
        rdy_mode = 0;
        run_idle();
        chk("t3_beats", beat, SZ);

        // 5: start while busy
        rdy_mode = 0;
        tlast_cnt = 0;
        start_line(0);
        run_to_beat(10);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t5_overrun", overrun, 1);
        step();
        chk("t5_overrun_pulse", overrun, 0);
        run_idle();
        chk("t5_tlast_cnt", tlast_cnt, 1);

        // 6: mid-line reset then restart from word 0
        start_line(0);
        run_to_beat(2000);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("t6_tvalid", m_axis_tvalid, 0);
        chk("t6_busy", busy, 0);
        step();
        tlast_cnt = 0;
        start_line(0);
        run_idle();
        chk("t6_beats", beat, SZ);
        chk("t6_tlast_cnt", tlast_cnt, 1);

        // 4: clear-on-read, then a second readout sees zeros
        rdy_mode = 1;
        start_line(1);
        run_idle();
        chk("t4_beats1", beat, SZ);
        start_line(0);
        run_idle();
        chk("t4_beats2", beat, SZ);
        chk("t4_mem_cleared", mem[SZ-1], 0);
        preload();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
